// File: rtl/arbitro_recurso_ie_pkg.sv
// Shared types for the IE01/IE02 resource arbiter: FSM states, owner tags and
// the 2-bit priority profile.
package arb_ie_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_IE01,
      GRANT_IE02,
      GAP
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IE01,
      OWN_IE02
   } owner_t;

   typedef logic [1:0] profile_t;

   localparam int unsigned GAP_W = 4;

endpackage

// File: rtl/arbitro_recurso_ie_if.sv
// Request/grant bundle between the two institutions and the arbiter.
// master = requester side (testbench / institutions), slave = arbiter.
interface arbitro_recurso_ie_if;
   import arb_ie_pkg::*;

   logic     req_ie01;
   logic     req_ie02;
   profile_t perf_ie01;
   profile_t perf_ie02;
   logic     gnt_ie01;
   logic     gnt_ie02;
   logic     busy;
   logic     timeout;
   logic     led_r;
   logic     led_g;
   logic     led_b;

   modport master (
      output req_ie01, req_ie02, perf_ie01, perf_ie02,
      input  gnt_ie01, gnt_ie02, busy, timeout, led_r, led_g, led_b
   );

   modport slave (
      input  req_ie01, req_ie02, perf_ie01, perf_ie02,
      output gnt_ie01, gnt_ie02, busy, timeout, led_r, led_g, led_b
   );

endinterface

// File: rtl/arbitro_recurso_ie_perfil_comparador.sv
// Combinational magnitude compare of two 2-bit priority profiles.
module perfil_comparador
   import arb_ie_pkg::*;
(
   input  profile_t i_a,
   input  profile_t i_b,
   output logic     o_eq,
   output logic     o_lt,
   output logic     o_gt
);

   assign o_eq = (i_a == i_b);
   assign o_lt = (i_a <  i_b);
   assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/arbitro_recurso_ie.sv
// Two-requester resource arbiter with grant hold, forced-release timeout, post-release
// gap and status LEDs. Define ROUND_ROBIN_TIE_EN to alternate the winner on equal profiles.
module arbitro_recurso_ie
   import arb_ie_pkg::*;
#(
   parameter int unsigned MAX_HOLD   = 16,
   parameter int unsigned GAP_CYCLES = 1
)
(
   input  logic                 clk,
   input  logic                 rst,
   arbitro_recurso_ie_if.slave  io_bus
);

   localparam int unsigned        HOLD_W   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_CYCLES);

   state_t              r_state;
   logic [HOLD_W-1:0]   r_hold;
   logic [GAP_W-1:0]    r_gap;
   owner_t              r_penalty;
   logic                r_gnt01;
   logic                r_gnt02;
   logic                r_busy;
   logic                r_timeout;
   logic                r_led_r;
   logic                r_led_g;
   logic                r_led_b;
`ifdef ROUND_ROBIN_TIE_EN
   owner_t              r_last;
`endif

   logic                w_eq;
   logic                w_lt;
   logic                w_gt;
   owner_t              w_winner;
   logic                w_req_own;
   logic                w_expire;

   perfil_comparador u_cmp (
      .i_a  (io_bus.perf_ie01),
      .i_b  (io_bus.perf_ie02),
      .o_eq (w_eq),
      .o_lt (w_lt),
      .o_gt (w_gt)
   );

   // A pending penalty overrides the profile compare; ties fall to the tie policy.
   always_comb begin
      w_winner = OWN_NONE;
      if (io_bus.req_ie01 && !io_bus.req_ie02) begin
         w_winner = OWN_IE01;
      end else if (!io_bus.req_ie01 && io_bus.req_ie02) begin
         w_winner = OWN_IE02;
      end else if (io_bus.req_ie01 && io_bus.req_ie02) begin
         if (r_penalty == OWN_IE01) begin
            w_winner = OWN_IE02;
         end else if (r_penalty == OWN_IE02) begin
            w_winner = OWN_IE01;
         end else if (w_gt) begin
            w_winner = OWN_IE01;
         end else if (w_lt) begin
            w_winner = OWN_IE02;
         end else if (w_eq) begin
`ifdef ROUND_ROBIN_TIE_EN
            w_winner = (r_last == OWN_IE01) ? OWN_IE02 : OWN_IE01;
`else
            w_winner = OWN_IE01;
`endif
         end
      end
   end

   assign w_req_own = (r_state == GRANT_IE01) ? io_bus.req_ie01 : io_bus.req_ie02;
   assign w_expire  = (MAX_HOLD != 0) && (r_hold == HOLD_MAX) && w_req_own;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_hold    <= '0;
         r_gap     <= '0;
         r_penalty <= OWN_NONE;
         r_gnt01   <= 1'b0;
         r_gnt02   <= 1'b0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_led_r   <= 1'b0;
         r_led_g   <= 1'b1;
         r_led_b   <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_winner != OWN_NONE) begin
                  r_state   <= (w_winner == OWN_IE01) ? GRANT_IE01 : GRANT_IE02;
                  r_hold    <= HOLD_W'(1);
                  r_penalty <= OWN_NONE;
                  r_gnt01   <= (w_winner == OWN_IE01);
                  r_gnt02   <= (w_winner == OWN_IE02);
                  r_busy    <= 1'b1;
                  r_led_b   <= (w_winner == OWN_IE01);
                  r_led_r   <= (w_winner == OWN_IE02);
                  r_led_g   <= 1'b0;
               end
            end
            GRANT_IE01, GRANT_IE02: begin
               if (!w_req_own || w_expire) begin
                  r_state   <= GAP;
                  r_gap     <= GAP_W'(1);
                  r_hold    <= '0;
                  r_timeout <= w_expire;
                  r_penalty <= !w_expire ? OWN_NONE :
                               (r_state == GRANT_IE01) ? OWN_IE01 : OWN_IE02;
                  r_gnt01   <= 1'b0;
                  r_gnt02   <= 1'b0;
                  r_busy    <= 1'b0;
                  r_led_b   <= 1'b0;
                  r_led_r   <= 1'b0;
               end else if (r_hold != '1) begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            GAP: begin
               if (r_gap == GAP_LAST) begin
                  r_state <= IDLE;
                  r_gap   <= '0;
                  r_led_g <= 1'b1;
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef ROUND_ROBIN_TIE_EN
   // Reset to IE02 so the very first tie goes to IE01.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= OWN_IE02;
      end else if (r_state == IDLE && w_winner != OWN_NONE) begin
         r_last <= w_winner;
      end
   end
`endif

   assign io_bus.gnt_ie01 = r_gnt01;
   assign io_bus.gnt_ie02 = r_gnt02;
   assign io_bus.busy     = r_busy;
   assign io_bus.timeout  = r_timeout;
   assign io_bus.led_r    = r_led_r;
   assign io_bus.led_g    = r_led_g;
   assign io_bus.led_b    = r_led_b;

   a_gnt_exclusive: assert property (@(posedge clk) disable iff (rst) !(r_gnt01 && r_gnt02));

endmodule

// File: tb/tb_arbitro_recurso_ie.sv
// Self-checking bench for arbitro_recurso_ie (MAX_HOLD=4, GAP_CYCLES=1): per-cycle
// compare against a behavioural model plus hand-computed checkpoints.
module tb_arbitro_recurso_ie;

   localparam int MAXH = 4;
   localparam int GAPC = 1;
`ifdef ROUND_ROBIN_TIE_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   arbitro_recurso_ie_if bus_if ();

   arbitro_recurso_ie #(.MAX_HOLD(MAXH), .GAP_CYCLES(GAPC)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int own;   // 0 free, 1 IE01, 2 IE02
      int held;  // cycles the current owner has held the grant
      int gap;   // idle cycles still to wait before arbitration
      int pen;   // penalised requester, 0 none
      int last;  // last granted requester
      bit to;
   } mdl_t;

   localparam mdl_t MDL_RST = '{own: 0, held: 0, gap: 0, pen: 0, last: 2, to: 1'b0};
   mdl_t m = MDL_RST;

   function automatic mdl_t step(mdl_t s, bit r1, bit r2, int p1, int p2);
      mdl_t n = s;
      int   w = 0;
      n.to = 1'b0;
      if (s.own == 0 && s.gap == 0) begin
         if (r1 && !r2)      w = 1;
         else if (r2 && !r1) w = 2;
         else if (r1 && r2) begin
            if (s.pen == 1)      w = 2;
            else if (s.pen == 2) w = 1;
            else if (p1 > p2)    w = 1;
            else if (p2 > p1)    w = 2;
            else                 w = RR ? ((s.last == 1) ? 2 : 1) : 1;
         end
         if (w != 0) begin
            n.own = w; n.held = 1; n.pen = 0; n.last = w;
         end
      end else if (s.own != 0) begin
         bit r;
         r = (s.own == 1) ? r1 : r2;
         if (!r) begin
            n.own = 0; n.gap = GAPC; n.pen = 0;
         end else if (MAXH > 0 && s.held == MAXH) begin
            n.own = 0; n.gap = GAPC; n.pen = s.own; n.to = 1'b1;
         end else begin
            n.held = s.held + 1;
         end
      end else begin
         n.gap = s.gap - 1;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= MDL_RST;
      else     m <= step(m, bus_if.req_ie01, bus_if.req_ie02,
                         int'(bus_if.perf_ie01), int'(bus_if.perf_ie02));
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      chk("cyc_gnt_ie01", 8'(bus_if.gnt_ie01), 8'(m.own == 1));
      chk("cyc_gnt_ie02", 8'(bus_if.gnt_ie02), 8'(m.own == 2));
      chk("cyc_busy",     8'(bus_if.busy),     8'(m.own != 0));
      chk("cyc_timeout",  8'(bus_if.timeout),  8'(m.to));
      chk("cyc_led_r",    8'(bus_if.led_r),    8'(m.own == 2));
      chk("cyc_led_g",    8'(bus_if.led_g),    8'(m.own == 0 && m.gap == 0));
      chk("cyc_led_b",    8'(bus_if.led_b),    8'(m.own == 1));
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_w [3];
      int win;
      exp_w = RR ? '{1, 2, 1} : '{1, 1, 1};

      rst = 1'b1;
      bus_if.req_ie01 = 1'b1; bus_if.req_ie02 = 1'b1;
      bus_if.perf_ie01 = 2'd2; bus_if.perf_ie02 = 2'd2;
      #2;
      chk("rst_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd0);
      chk("rst_gnt_ie02", 8'(bus_if.gnt_ie02), 8'd0);
      chk("rst_led_g",    8'(bus_if.led_g),    8'd1);
      chk("rst_busy",     8'(bus_if.busy),     8'd0);
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      chk("tie_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd1);
      chk("tie_gnt_ie02", 8'(bus_if.gnt_ie02), 8'd0);
      chk("tie_led_b",    8'(bus_if.led_b),    8'd1);
      bus_if.req_ie01 = 1'b0; bus_if.req_ie02 = 1'b0;
      cyc(); cyc();

      // Higher profile wins; after its release IE01 follows through GAP and IDLE.
      bus_if.perf_ie01 = 2'd1; bus_if.perf_ie02 = 2'd3;
      bus_if.req_ie01 = 1'b1; bus_if.req_ie02 = 1'b1;
      cyc();
      chk("perf_gnt_ie02", 8'(bus_if.gnt_ie02), 8'd1);
      chk("perf_led_r",    8'(bus_if.led_r),    8'd1);
      bus_if.req_ie02 = 1'b0;
      cyc();
      chk("gap_gnt_ie02", 8'(bus_if.gnt_ie02), 8'd0);
      chk("gap_led_g",    8'(bus_if.led_g),    8'd0);
      cyc();
      chk("idle_led_g",   8'(bus_if.led_g),    8'd1);
      cyc();
      chk("next_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd1);
      bus_if.req_ie01 = 1'b0;
      cyc(); cyc();

      // Forced release after MAX_HOLD, then penalty hands the resource to IE02.
      bus_if.perf_ie01 = 2'd2; bus_if.perf_ie02 = 2'd1;
      bus_if.req_ie01 = 1'b1; bus_if.req_ie02 = 1'b1;
      cyc(); cyc(); cyc(); cyc();
      chk("hold4_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd1);
      cyc();
      chk("to_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd0);
      chk("to_pulse",    8'(bus_if.timeout),  8'd1);
      cyc();
      chk("to_end",      8'(bus_if.timeout),  8'd0);
      chk("to_led_g",    8'(bus_if.led_g),    8'd1);
      cyc();
      chk("pen_gnt_ie02", 8'(bus_if.gnt_ie02), 8'd1);

      // No preemption while IE01 holds, even when IE02 raises its profile.
      bus_if.req_ie02 = 1'b0;
      cyc(); cyc(); cyc();
      chk("hold_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd1);
      bus_if.perf_ie02 = 2'd3; bus_if.req_ie02 = 1'b1;
      cyc(); cyc();
      chk("nopre_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd1);
      chk("nopre_gnt_ie02", 8'(bus_if.gnt_ie02), 8'd0);
      bus_if.req_ie01 = 1'b0;
      cyc();
      chk("rel_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd0);
      chk("rel_timeout",  8'(bus_if.timeout),  8'd0);
      cyc(); cyc();
      chk("after_gnt_ie02", 8'(bus_if.gnt_ie02), 8'd1);
      bus_if.req_ie02 = 1'b0;
      cyc(); cyc();

      // Repeated ties.
      bus_if.perf_ie01 = 2'd1; bus_if.perf_ie02 = 2'd1;
      for (int i = 0; i < 3; i++) begin
         bus_if.req_ie01 = 1'b1; bus_if.req_ie02 = 1'b1;
         win = 0;
         for (int k = 0; k < 8 && win == 0; k++) begin
            cyc();
            win = bus_if.gnt_ie01 ? 1 : (bus_if.gnt_ie02 ? 2 : 0);
         end
         chk("tie_winner", 8'(win), 8'(exp_w[i]));
         bus_if.req_ie01 = 1'b0; bus_if.req_ie02 = 1'b0;
         cyc(); cyc();
      end

      // Asynchronous reset between edges while IE01 holds.
      bus_if.req_ie01 = 1'b1;
      cyc(); cyc();
      chk("pre_rst_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_gnt_ie01", 8'(bus_if.gnt_ie01), 8'd0);
      chk("arst_busy",     8'(bus_if.busy),     8'd0);
      chk("arst_led_g",    8'(bus_if.led_g),    8'd1);
      chk("arst_led_b",    8'(bus_if.led_b),    8'd0);
      chk("arst_timeout",  8'(bus_if.timeout),  8'd0);
      cyc();
      rst = 1'b0;
      bus_if.req_ie01 = 1'b0;
      cyc(); cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/arbitro_recurso_ie.md
Name: arbitro_recurso_ie

Overview:
- Sequential two-requester arbiter that shares one resource between institutions IE01 and IE02.
- Each request carries a 2-bit priority profile; the higher profile wins and ties go to IE01.
- Adds grant hold, a forced-release timeout, a post-release gap, and RGB status LEDs.
- Sits between the two institution request interfaces and the shared resource.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles before forced release; 0 disables the timeout
GAP_CYCLES, 1, idle cycles inserted after every release; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_ie01  input  1  IE01 request, level; held until done
req_ie02  input  1  IE02 request, level
perf_ie01  input  2  IE01 priority profile (3 = highest)
perf_ie02  input  2  IE02 priority profile
gnt_ie01  output  1  resource granted to IE01 (registered)
gnt_ie02  output  1  resource granted to IE02 (registered)
busy  output  1  resource owned (gnt_ie01 | gnt_ie02)
timeout  output  1  one-cycle pulse on forced release
led_r  output  1  lit while IE02 holds the grant
led_g  output  1  lit while in IDLE (resource free)
led_b  output  1  lit while IE01 holds the grant

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values (asserted immediately, independent of clk): state IDLE; gnt_ie01=0, gnt_ie02=0, busy=0, timeout=0, led_r=0, led_g=1, led_b=0; hold and gap counters 0; penalty flag cleared.
- States: IDLE, GRANT_IE01, GRANT_IE02, GAP.
- IDLE, arbitration at each edge:
  - Only one req high: grant that requester.
  - Both high: higher perf wins.
  - perf equal: IE01 wins.
  - Penalty flag set and the non-penalised requester is requesting: that requester wins regardless of perf.
  - Profiles are sampled only at this edge.
  - Grant latency: req sampled high at edge k gives gnt high after edge k, i.e. 1 cycle.
- GRANT_x:
  - Hold counter increments each cycle.
  - req_x low at an edge: gnt drops after that edge, go to GAP, penalty cleared.
  - MAX_HOLD>0 and the counter reaches MAX_HOLD cycles with req_x still high: forced release. gnt drops, timeout pulses for 1 cycle, penalty flag marks x, go to GAP.
  - perf changes and the other requester's req are ignored while granted.
- GAP:
  - Counts GAP_CYCLES with both gnt low and all LEDs low.
  - Then returns to IDLE.
  - Requests present are arbitrated on the first IDLE edge.
- Penalty flag clears after it has been applied once, or when the penalised requester is the only one requesting.
- gnt_ie01 and gnt_ie02 are never both high (assertion required).
- Reset asserted mid-grant drops the grant immediately; no timeout pulse.
- A request deasserted during GAP or IDLE before the arbitration edge is simply not granted.

Optional Feature:
- Macro ROUND_ROBIN_TIE_EN.
- Defined: on equal perf, the winner alternates, via a last-winner register reset to IE02 so that IE01 wins the first tie.
- Undefined: equal perf always goes to IE01.
- Penalty rule applies in both cases.

Decomposition:
- Package arb_ie_pkg: state enum (IDLE, GRANT_IE01, GRANT_IE02, GAP), owner enum (OWN_NONE, OWN_IE01, OWN_IE02), profile typedef logic [1:0].
- Sub-module perfil_comparador: combinational 2-bit magnitude compare with outputs eq, lt, gt; instantiated once for the IDLE decision.

Test Plan:
- Reset with both reqs high: outputs at reset values; after rst release, edge 1 gives gnt_ie01=1 only when perf_ie01=2, perf_ie02=2 (tie to IE01).
- perf_ie01=1, perf_ie02=3, both req: gnt_ie02=1, led_r=1; drop req_ie02 → gnt low, GAP 1 cycle, then gnt_ie01=1.
- MAX_HOLD=4, req_ie01 held, req_ie02 high with lower perf: gnt_ie01 high exactly 4 cycles, timeout pulse 1 cycle, then gnt_ie02 despite lower perf.
- Change perf_ie02 to 3 while IE01 holds: no preemption; gnt_ie01 stays until req_ie01 drops.
- ROUND_ROBIN_TIE_EN, equal perf, repeated both-request cycles: grants alternate IE01, IE02, IE01.
- rst pulse mid-grant, asynchronous and between clock edges: gnt drops immediately, led_g=1, timeout=0.
